// File: rtl/pending_req_encoder_pkg.sv
// Shared definitions for the pending request encoder.
//   REQ_W       : number of request lines
//   CODE_W      : width of the binary request index
//   enc_state_e : presenter state (IDLE = nothing offered, PRESENT = code offered)
//   onehot()    : expands a request index into a REQ_W-bit one-hot mask
package pending_req_encoder_pkg;

   localparam int REQ_W  = 8;
   localparam int CODE_W = 3;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } enc_state_e;

   function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] idx);
      return {{(REQ_W-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/pending_req_encoder_prio_select8.sv
// Combinational selector over an 8-bit request vector.
//   vec   : candidate request bits
//   start : first index examined in round-robin mode (ignored in fixed mode)
//   sel   : chosen index (3'd0 when nothing is set)
//   any   : at least one bit of vec is set
// Fixed mode picks the highest set index. Round-robin mode walks upward from
// start with wrap 7->0 and picks the first set bit it meets.
module prio_select8
   import pending_req_encoder_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b0
) (
   input  logic [REQ_W-1:0]  vec,
   input  logic [CODE_W-1:0] start,
   output logic [CODE_W-1:0] sel,
   output logic              any
);

   // Index search; later loop iterations override earlier ones, so the loop
   // order decides which set bit wins.
   always_comb begin
      sel = {CODE_W{1'b0}};
      any = |vec;
      if (ROUND_ROBIN) begin
         // Largest offset first, so the smallest offset from start wins.
         for (int i = REQ_W - 1; i >= 0; i--) begin
            sel = vec[start + CODE_W'(i)] ? (start + CODE_W'(i)) : sel;
         end
      end else begin
         // Lowest index first, so the highest set index wins.
         for (int i = 0; i < REQ_W; i++) begin
            sel = vec[i] ? CODE_W'(i) : sel;
         end
      end
   end

endmodule

// File: rtl/pending_req_encoder.sv
// Pending request encoder: collects request pulses into a sticky pending
// vector and offers one pending index at a time through a valid/ready handshake.
//   clk     : single clock, rising edge
//   rst     : synchronous active-high reset
//   req     : request lines, OR-ed into pending on every edge
//   code    : binary index of the offered request (3'd0 while valid=0)
//   valid   : code is offered and held stable until accepted
//   ready   : consumer takes code on an edge where valid & ready
//   pending : registered pending-request vector
//   drop    : one-cycle pulse when a request hit a bit that was already pending
module pending_req_encoder
   import pending_req_encoder_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REQ_W-1:0]  req,
   input  logic              ready,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic [REQ_W-1:0]  pending,
   output logic              drop
);

   enc_state_e        state_r, state_nxt_s;
   logic [CODE_W-1:0] code_r, code_nxt_s;
   logic              valid_r, valid_nxt_s;
   logic [CODE_W-1:0] last_served_r, last_served_nxt_s;
   logic [REQ_W-1:0]  pending_r, pending_nxt_s;
   logic [REQ_W-1:0]  clr_mask_s;
   logic              drop_r, drop_nxt_s;
   logic              accept_s;
   logic [REQ_W-1:0]  sel_vec_s;
   logic [CODE_W-1:0] sel_start_s;
   logic [CODE_W-1:0] sel_code_s;
   logic              sel_any_s;

   // Pending-vector update: clear the accepted bit, then OR in new requests so a
   // fresh request on the bit being served survives.
   always_comb begin
      accept_s      = valid_r & ready;
      clr_mask_s    = accept_s ? onehot(code_r) : {REQ_W{1'b0}};
      pending_nxt_s = (pending_r & ~clr_mask_s) | req;
      drop_nxt_s    = |(req & pending_r & ~clr_mask_s);
   end

   // Selector operands. From IDLE the choice is made over the pending vector as
   // it stands; after an accept it is made over the updated vector, with the
   // round-robin search starting just above the code being accepted.
   always_comb begin
      sel_vec_s   = pending_r;
      sel_start_s = last_served_r + 3'd1;
      case (state_r)
         IDLE: begin
            sel_vec_s   = pending_r;
            sel_start_s = last_served_r + 3'd1;
         end
         PRESENT: begin
            sel_vec_s   = pending_nxt_s;
            sel_start_s = code_r + 3'd1;
         end
         default: begin
            sel_vec_s   = pending_r;
            sel_start_s = last_served_r + 3'd1;
         end
      endcase
   end

   prio_select8 #(
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_prio_select8 (
      .vec   (sel_vec_s),
      .start (sel_start_s),
      .sel   (sel_code_s),
      .any   (sel_any_s)
   );

   // Next-state and presented-code logic.
   always_comb begin
      state_nxt_s       = state_r;
      code_nxt_s        = code_r;
      valid_nxt_s       = valid_r;
      last_served_nxt_s = last_served_r;
      case (state_r)
         IDLE: begin
            if (sel_any_s) begin
               state_nxt_s = PRESENT;
               code_nxt_s  = sel_code_s;
               valid_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
               code_nxt_s  = {CODE_W{1'b0}};
               valid_nxt_s = 1'b0;
            end
         end
         PRESENT: begin
            if (accept_s) begin
               last_served_nxt_s = code_r;
               if (sel_any_s) begin
                  state_nxt_s = PRESENT;
                  code_nxt_s  = sel_code_s;
                  valid_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
                  code_nxt_s  = {CODE_W{1'b0}};
                  valid_nxt_s = 1'b0;
               end
            end else begin
               // Offer is held untouched until the consumer takes it.
               state_nxt_s = PRESENT;
               code_nxt_s  = code_r;
               valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            code_nxt_s  = {CODE_W{1'b0}};
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath registers; reset discards anything requested or offered.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_r        <= {CODE_W{1'b0}};
         valid_r       <= 1'b0;
         last_served_r <= 3'd7;
         pending_r     <= {REQ_W{1'b0}};
         drop_r        <= 1'b0;
      end else begin
         code_r        <= code_nxt_s;
         valid_r       <= valid_nxt_s;
         last_served_r <= last_served_nxt_s;
         pending_r     <= pending_nxt_s;
         drop_r        <= drop_nxt_s;
      end
   end

   assign code    = code_r;
   assign valid   = valid_r;
   assign pending = pending_r;
   assign drop    = drop_r;

endmodule
